// File: rtl/dcpu_loader_if.sv
// ---------------------------------------------------------------------------
// dcpu_loader_if
//
// Bundles every non-clock signal of the dCPU boot/run sequencer: the program
// load stream, the CPU-side memory port, the physical memory port, the dump
// stream and the status outputs.
//
// Modports:
//   slave  - the dcpu_loader itself (drives in_ready, cpu_rst, mem_*,
//            out_valid/out_data and status)
//   master - the surrounding system (host, dCPU core and memory macro)
//
// Signal summary:
//   start, load_len, in_valid, in_data, in_ready  program load stream
//   cpu_rst, cpu_R, cpu_W, cpu_addr, cpu_wdata,
//   cpu_stop                                      dCPU control and memory port
//   mem_R, mem_W, mem_addr, mem_wdata, mem_rdata  physical 256x8 memory port
//   out_valid, out_data, out_ready                result dump stream
//   busy, done, timeout, run_cycles, checksum     status
// ---------------------------------------------------------------------------
interface dcpu_loader_if;
    // Program load stream
    logic        start;
    logic [7:0]  load_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;

    // dCPU side
    logic        cpu_rst;
    logic        cpu_R;
    logic        cpu_W;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_stop;

    // Physical memory port (strobes active low)
    logic        mem_R;
    logic        mem_W;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    // Result dump stream
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    // Status
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] run_cycles;
    logic [7:0]  checksum;

    modport slave (
        input  start, load_len, in_valid, in_data,
        input  cpu_R, cpu_W, cpu_addr, cpu_wdata, cpu_stop,
        input  mem_rdata, out_ready,
        output in_ready, cpu_rst,
        output mem_R, mem_W, mem_addr, mem_wdata,
        output out_valid, out_data,
        output busy, done, timeout, run_cycles, checksum
    );

    modport master (
        output start, load_len, in_valid, in_data,
        output cpu_R, cpu_W, cpu_addr, cpu_wdata, cpu_stop,
        output mem_rdata, out_ready,
        input  in_ready, cpu_rst,
        input  mem_R, mem_W, mem_addr, mem_wdata,
        input  out_valid, out_data,
        input  busy, done, timeout, run_cycles, checksum
    );
endinterface

// File: rtl/dcpu_loader.sv
// ---------------------------------------------------------------------------
// dcpu_loader
//
// Boot and run sequencer for the dCPU core and its 256-byte single-port
// memory. It holds the CPU in reset while a program streams into memory,
// releases the CPU until it raises STOP (or the watchdog expires), then
// streams a fixed window of memory back out. The loader owns the memory port
// and muxes it between the load stream, the CPU and the dump logic.
//
// Ports:
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    dcpu_loader_if.slave (load stream, CPU port, memory port,
//          dump stream, status)
//
// Parameters:
//   MAX_RUN_CYCLES  watchdog limit in RUN cycles, 0 disables the watchdog
//   DUMP_BASE       first memory address streamed out after the run
//   DUMP_LEN        number of bytes dumped, 1..256
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, checksum is the mod-256 sum of the
//                       bytes accepted during the last load; otherwise it
//                       is tied to 8'h00 and no adder is built.
// ---------------------------------------------------------------------------
module dcpu_loader #(
    parameter logic [15:0] MAX_RUN_CYCLES = 16'd4096,
    parameter logic [7:0]  DUMP_BASE      = 8'hF0,
    parameter logic [8:0]  DUMP_LEN       = 9'd16
) (
    input  logic          clk,
    input  logic          rst_n,
    dcpu_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    // Value of run_cycles in the last RUN cycle the watchdog allows.
    localparam logic [15:0] WD_LAST   = MAX_RUN_CYCLES - 16'd1;
    // Value of the dump counter on the final transfer.
    localparam logic [8:0]  DUMP_LAST = DUMP_LEN - 9'd1;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_wptr;        // next load address
    logic [8:0]  r_remaining;   // bytes still to load, 256 encoded as 9'h100
    logic [7:0]  r_dptr;        // next dump address, wraps FF -> 00
    logic [8:0]  r_dcount;      // dump transfers completed
    logic [15:0] r_run_cycles;
    logic        r_timeout;
    logic        r_cpu_rst;

    logic        w_start_ok;
    logic        w_load_acc;
    logic        w_load_last;
    logic        w_watchdog;
    logic        w_dump_acc;
    logic        w_dump_last;

    logic        w_in_ready;
    logic        w_mem_R;
    logic        w_mem_W;
    logic [7:0]  w_mem_addr;
    logic [7:0]  w_mem_wdata;
    logic        w_out_valid;
    logic [7:0]  w_out_data;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_start_ok  = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_load_acc  = (r_state == S_LOAD) && bus.in_valid;
    assign w_load_last = w_load_acc && (r_remaining == 9'd1);
    assign w_watchdog  = (MAX_RUN_CYCLES != 16'd0) && (r_run_cycles == WD_LAST);
    assign w_dump_acc  = (r_state == S_DUMP) && bus.out_ready;
    assign w_dump_last = w_dump_acc && (r_dcount == DUMP_LAST);

    // ------------------------------------------------------------------
    // Next state and memory-port mux
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_mem_R     = 1'b1;
        w_mem_W     = 1'b1;
        w_mem_addr  = 8'h00;
        w_mem_wdata = 8'h00;
        w_out_valid = 1'b0;
        w_out_data  = 8'h00;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_next = S_LOAD;
                end
            end

            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_mem_W     = 1'b0;
                    w_mem_addr  = r_wptr;
                    w_mem_wdata = bus.in_data;
                end
                if (w_load_last) begin
                    w_next = S_RUN;
                end
            end

            S_RUN: begin
                // The CPU owns the memory port only while it runs; its
                // strobes are ignored in every other state.
                w_mem_R     = bus.cpu_R;
                w_mem_W     = bus.cpu_W;
                w_mem_addr  = bus.cpu_addr;
                w_mem_wdata = bus.cpu_wdata;
                if (bus.cpu_stop || w_watchdog) begin
                    w_next = S_DUMP;
                end
            end

            S_DUMP: begin
                // Read data is valid in the same cycle as mem_R, and dptr only
                // moves on out_ready, so out_data holds during stalls.
                w_mem_R     = 1'b0;
                w_mem_addr  = r_dptr;
                w_out_valid = 1'b1;
                w_out_data  = bus.mem_rdata;
                if (w_dump_last) begin
                    w_next = S_DONE;
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, counters and status
    // ------------------------------------------------------------------
    // NOTE: only control state is reset here; the memory array sits outside
    // this block and its contents deliberately survive a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= 8'h00;
            r_remaining  <= 9'd0;
            r_dptr       <= 8'h00;
            r_dcount     <= 9'd0;
            r_run_cycles <= 16'd0;
            r_timeout    <= 1'b0;
            r_cpu_rst    <= 1'b1;
        end else begin
            // Registered so the CPU reset is glitch-free and releases on the
            // same edge the state becomes RUN.
            r_cpu_rst <= (w_next != S_RUN);

            if (w_start_ok) begin
                r_wptr       <= 8'h00;
                r_remaining  <= {bus.load_len == 8'h00, bus.load_len};
                r_timeout    <= 1'b0;
                r_run_cycles <= 16'd0;
            end

            if (w_load_acc) begin
                r_wptr      <= r_wptr + 8'd1;
                r_remaining <= r_remaining - 9'd1;
            end

            if (r_state == S_RUN) begin
                if (w_next == S_RUN) begin
                    // The exit cycle is not counted, so a watchdog expiry
                    // leaves run_cycles at MAX_RUN_CYCLES-1.
                    if (r_run_cycles != 16'hFFFF) begin
                        r_run_cycles <= r_run_cycles + 16'd1;
                    end
                end else begin
                    // Leaving RUN without STOP can only be the watchdog;
                    // STOP wins when both happen together.
                    r_timeout <= !bus.cpu_stop;
                    r_dptr    <= DUMP_BASE;
                    r_dcount  <= 9'd0;
                end
            end

            if (w_dump_acc) begin
                r_dptr   <= r_dptr + 8'd1;
                r_dcount <= r_dcount + 9'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional load checksum
    // ------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 8'h00;
        end else if (w_start_ok) begin
            r_checksum <= 8'h00;
        end else if (w_load_acc) begin
            r_checksum <= r_checksum + bus.in_data;
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = w_in_ready;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.mem_R      = w_mem_R;
    assign bus.mem_W      = w_mem_W;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_data;
    assign bus.busy       = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DUMP);
    assign bus.done       = (r_state == S_DONE);
    assign bus.timeout    = r_timeout;
    assign bus.run_cycles = r_run_cycles;

endmodule

// File: tb/tb_dcpu_loader.sv
// ---------------------------------------------------------------------------
// tb_dcpu_loader
//
// Two loader instances share clk/rst_n:
//   [0] MAX_RUN_CYCLES=16, DUMP_BASE=8'h10, DUMP_LEN=1
//   [1] watchdog disabled, DUMP_BASE=8'hFE, DUMP_LEN=4
// Each drives its own 256x8 memory inside the bench. A per-instance
// behavioural model predicts every output on every falling edge; directed
// sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_dcpu_loader;

    typedef enum int {PH_IDLE, PH_LOAD, PH_RUN, PH_DUMP, PH_DONE} ph_t;
    typedef enum int {W_RUN, W_DUMP, W_DONE} wait_t;

    typedef struct packed {
        logic       start;
        logic [7:0] load_len;
        logic       in_valid;
        logic [7:0] in_data;
        logic       cpu_R;
        logic       cpu_W;
        logic [7:0] cpu_addr;
        logic [7:0] cpu_wdata;
        logic       cpu_stop;
        logic       out_ready;
    } stim_t;

    typedef struct packed {
        logic        cpu_rst;
        logic        busy;
        logic        done;
        logic        in_ready;
        logic        mem_R;
        logic        mem_W;
        logic [7:0]  mem_addr;
        logic [7:0]  mem_wdata;
        logic        out_valid;
        logic [7:0]  out_data;
        logic        timeout;
        logic [15:0] run_cycles;
        logic [7:0]  checksum;
    } obs_t;

`ifdef LOADER_CHECKSUM_EN
    localparam logic [7:0] EXP_CKS3 = 8'h71;   // 3C+A5+0F+81 mod 256
`else
    localparam logic [7:0] EXP_CKS3 = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int p_max  [2] = '{16, 0};
    int p_base [2] = '{16, 254};
    int p_len  [2] = '{1, 4};

    stim_t      stim [2];
    obs_t       obs  [2];
    logic [7:0] env_mem [2][256];
    int         wcnt [2];
    bit         env_init = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    dcpu_loader_if bif [2] ();

    dcpu_loader #(.MAX_RUN_CYCLES(16'd16), .DUMP_BASE(8'h10), .DUMP_LEN(9'd1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bif[0].slave));
    dcpu_loader #(.MAX_RUN_CYCLES(16'd0), .DUMP_BASE(8'hFE), .DUMP_LEN(9'd4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bif[1].slave));

    for (genvar g = 0; g < 2; g++) begin : g_conn
        assign bif[g].start     = stim[g].start;
        assign bif[g].load_len  = stim[g].load_len;
        assign bif[g].in_valid  = stim[g].in_valid;
        assign bif[g].in_data   = stim[g].in_data;
        assign bif[g].cpu_R     = stim[g].cpu_R;
        assign bif[g].cpu_W     = stim[g].cpu_W;
        assign bif[g].cpu_addr  = stim[g].cpu_addr;
        assign bif[g].cpu_wdata = stim[g].cpu_wdata;
        assign bif[g].cpu_stop  = stim[g].cpu_stop;
        assign bif[g].out_ready = stim[g].out_ready;
        assign bif[g].mem_rdata = env_mem[g][bif[g].mem_addr];
        assign obs[g] = '{cpu_rst: bif[g].cpu_rst, busy: bif[g].busy, done: bif[g].done,
                          in_ready: bif[g].in_ready, mem_R: bif[g].mem_R, mem_W: bif[g].mem_W,
                          mem_addr: bif[g].mem_addr, mem_wdata: bif[g].mem_wdata,
                          out_valid: bif[g].out_valid, out_data: bif[g].out_data,
                          timeout: bif[g].timeout, run_cycles: bif[g].run_cycles,
                          checksum: bif[g].checksum};
    end

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Memory macros driven by the loaders' physical ports.
    always @(posedge clk) begin
        if (!env_init) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 256; i++) env_mem[k][i] <= init_byte(i);
                wcnt[k] <= 0;
            end
            env_init <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!obs[k].mem_W) begin
                    env_mem[k][obs[k].mem_addr] <= obs[k].mem_wdata;
                    wcnt[k] <= wcnt[k] + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model and per-cycle comparison
    // ------------------------------------------------------------------
    ph_t        m_ph   [2];
    int         m_wptr [2];
    int         m_left [2];
    int         m_runc [2];
    int         m_didx [2];
    bit         m_to   [2];
    logic [7:0] m_cks  [2];
    logic [7:0] m_mem  [2][256];

    initial begin : compare
        stim_t      s;
        obs_t       o;
        ph_t        ph;
        logic       e_w, e_r;
        logic [7:0] e_cks;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) m_mem[k][i] = init_byte(i);
            m_ph[k] = PH_IDLE; m_wptr[k] = 0; m_left[k] = 0; m_runc[k] = 0;
            m_didx[k] = 0; m_to[k] = 1'b0; m_cks[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                s = stim[k];
                o = obs[k];
                if (!rst_n) begin
                    check("rst_cpu_rst", k, o.cpu_rst, 1'b1);
                    check("rst_busy", k, o.busy, 1'b0);
                    check("rst_done", k, o.done, 1'b0);
                    check("rst_mem_R", k, o.mem_R, 1'b1);
                    check("rst_mem_W", k, o.mem_W, 1'b1);
                    check("rst_in_ready", k, o.in_ready, 1'b0);
                    check("rst_out_valid", k, o.out_valid, 1'b0);
                    check("rst_timeout", k, o.timeout, 1'b0);
                    check("rst_run_cycles", k, o.run_cycles, 16'd0);
                    check("rst_checksum", k, o.checksum, 8'h00);
                    m_ph[k] = PH_IDLE; m_wptr[k] = 0; m_left[k] = 0; m_runc[k] = 0;
                    m_didx[k] = 0; m_to[k] = 1'b0; m_cks[k] = 8'h00;
                end else begin
                    ph = m_ph[k];
                    check("cpu_rst", k, o.cpu_rst, ph != PH_RUN);
                    check("busy", k, o.busy, ph == PH_LOAD || ph == PH_RUN || ph == PH_DUMP);
                    check("done", k, o.done, ph == PH_DONE);
                    check("in_ready", k, o.in_ready, ph == PH_LOAD);
                    check("out_valid", k, o.out_valid, ph == PH_DUMP);
                    e_w = (ph == PH_LOAD) ? !s.in_valid : (ph == PH_RUN) ? s.cpu_W : 1'b1;
                    e_r = (ph == PH_RUN) ? s.cpu_R : (ph == PH_DUMP) ? 1'b0 : 1'b1;
                    check("mem_W", k, o.mem_W, e_w);
                    check("mem_R", k, o.mem_R, e_r);
                    if (!e_w) begin
                        check("wr_addr", k, o.mem_addr, (ph == PH_LOAD) ? 8'(m_wptr[k]) : s.cpu_addr);
                        check("wr_data", k, o.mem_wdata, (ph == PH_LOAD) ? s.in_data : s.cpu_wdata);
                    end else if (!e_r) begin
                        check("rd_addr", k, o.mem_addr,
                              (ph == PH_RUN) ? s.cpu_addr : 8'(p_base[k] + m_didx[k]));
                    end
                    if (ph == PH_DUMP)
                        check("out_data", k, o.out_data, m_mem[k][8'(p_base[k] + m_didx[k])]);
                    check("timeout", k, o.timeout, m_to[k]);
                    check("run_cycles", k, o.run_cycles, 16'(m_runc[k]));
`ifdef LOADER_CHECKSUM_EN
                    e_cks = m_cks[k];
`else
                    e_cks = 8'h00;
`endif
                    check("checksum", k, o.checksum, e_cks);

                    // Advance the model by the edge that follows.
                    case (ph)
                        PH_IDLE, PH_DONE: if (s.start) begin
                            m_ph[k] = PH_LOAD; m_wptr[k] = 0;
                            m_left[k] = (s.load_len == 8'h00) ? 256 : int'(s.load_len);
                            m_to[k] = 1'b0; m_runc[k] = 0; m_cks[k] = 8'h00;
                        end
                        PH_LOAD: if (s.in_valid) begin
                            m_mem[k][8'(m_wptr[k])] = s.in_data;
                            m_cks[k] = m_cks[k] + s.in_data;
                            m_wptr[k] = (m_wptr[k] + 1) % 256;
                            m_left[k]--;
                            if (m_left[k] == 0) m_ph[k] = PH_RUN;
                        end
                        PH_RUN: begin
                            if (!s.cpu_W) m_mem[k][s.cpu_addr] = s.cpu_wdata;
                            if (s.cpu_stop) begin
                                m_ph[k] = PH_DUMP; m_didx[k] = 0;
                            end else if (p_max[k] != 0 && m_runc[k] == p_max[k] - 1) begin
                                m_ph[k] = PH_DUMP; m_didx[k] = 0; m_to[k] = 1'b1;
                            end else if (m_runc[k] < 65535) begin
                                m_runc[k]++;
                            end
                        end
                        PH_DUMP: if (s.out_ready) begin
                            m_didx[k]++;
                            if (m_didx[k] == p_len[k]) m_ph[k] = PH_DONE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int k, input logic [7:0] len);
        stim[k].start    = 1'b1;
        stim[k].load_len = len;
        tick();
        stim[k].start    = 1'b0;
    endtask

    task automatic feed(input int k, input logic [7:0] b);
        stim[k].in_valid = 1'b1;
        stim[k].in_data  = b;
        tick();
        stim[k].in_valid = 1'b0;
    endtask

    task automatic cpu_write(input int k, input logic [7:0] a, input logic [7:0] d);
        stim[k].cpu_W     = 1'b0;
        stim[k].cpu_addr  = a;
        stim[k].cpu_wdata = d;
        tick();
        stim[k].cpu_W     = 1'b1;
    endtask

    task automatic cpu_stop_now(input int k);
        stim[k].cpu_stop = 1'b1;
        tick();
        stim[k].cpu_stop = 1'b0;
    endtask

    task automatic wait_for(input int k, input wait_t what);
        bit hit = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            case (what)
                W_RUN:   hit = !obs[k].cpu_rst;
                W_DUMP:  hit = obs[k].out_valid;
                default: hit = obs[k].done;
            endcase
            if (hit) break;
            tick();
        end
        check("wait_bound", k, hit, 1'b1);
    endtask

    initial begin : stimulus
        int          wbase;
        int          n;
        logic [7:0]  prog2 [5] = '{8'hC0, 8'h05, 8'hC2, 8'h10, 8'hCC};
        logic [7:0]  prog3 [4] = '{8'h3C, 8'hA5, 8'h0F, 8'h81};
        bit          vpat  [6] = '{1, 0, 1, 1, 0, 1};
        bit          rpat  [6] = '{1, 0, 0, 1, 1, 1};
        logic [7:0]  ea    [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [7:0]  ed    [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

        for (int k = 0; k < 2; k++) begin
            stim[k]       = '0;
            stim[k].cpu_R = 1'b1;
            stim[k].cpu_W = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset, no start.
        repeat (5) tick();
        for (int k = 0; k < 2; k++) begin
            check("idle_cpu_rst", k, obs[k].cpu_rst, 1'b1);
            check("idle_mem_W", k, obs[k].mem_W, 1'b1);
            check("idle_busy", k, obs[k].busy, 1'b0);
            check("idle_done", k, obs[k].done, 1'b0);
        end

        // 2: five-byte program, CPU stores 05 at 10 and stops.
        do_start(0, 8'd5);
        wbase = wcnt[0];
        for (int i = 0; i < 5; i++) feed(0, prog2[i]);
        check("t2_writes", 0, wcnt[0] - wbase, 5);
        for (int i = 0; i < 5; i++) check("t2_mem", 0, env_mem[0][i], prog2[i]);
        check("t2_run", 0, obs[0].cpu_rst, 1'b0);
        stim[0].cpu_R = 1'b0; stim[0].cpu_addr = 8'h00;
        tick();
        stim[0].cpu_R = 1'b1;
        cpu_write(0, 8'h10, 8'h05);
        cpu_stop_now(0);
        check("t2_dump_valid", 0, obs[0].out_valid, 1'b1);
        check("t2_dump_addr", 0, obs[0].mem_addr, 8'h10);
        check("t2_dump_data", 0, obs[0].out_data, 8'h05);
        check("t2_run_cycles", 0, obs[0].run_cycles, 16'd2);
        stim[0].out_ready = 1'b1;
        tick();
        stim[0].out_ready = 1'b0;
        check("t2_done", 0, obs[0].done, 1'b1);
        check("t2_busy", 0, obs[0].busy, 1'b0);
        check("t2_timeout", 0, obs[0].timeout, 1'b0);

        // 4: jump-to-self program, watchdog of 16 cycles.
        do_start(0, 8'd2);
        feed(0, 8'hC4);
        feed(0, 8'h00);
        wait_for(0, W_DUMP);
        check("t4_timeout", 0, obs[0].timeout, 1'b1);
        check("t4_run_cycles", 0, obs[0].run_cycles, 16'd15);
        check("t4_dump_data", 0, obs[0].out_data, 8'h05);
        stim[0].out_ready = 1'b1;
        wait_for(0, W_DONE);
        stim[0].out_ready = 1'b0;
        check("t4_timeout_sticky", 0, obs[0].timeout, 1'b1);

        // 3: four-byte load with gaps in in_valid.
        do_start(1, 8'd4);
        wbase = wcnt[1];
        n = 0;
        for (int i = 0; i < 6; i++) begin
            stim[1].in_valid = vpat[i];
            stim[1].in_data  = vpat[i] ? prog3[n] : 8'hEE;
            tick();
            if (vpat[i]) n++;
        end
        stim[1].in_valid = 1'b0;
        check("t3_writes", 1, wcnt[1] - wbase, 4);
        for (int i = 0; i < 4; i++) check("t3_mem", 1, env_mem[1][i], prog3[i]);
        check("t3_checksum", 1, obs[1].checksum, EXP_CKS3);
        check("t3_run", 1, obs[1].cpu_rst, 1'b0);

        // 5: CPU fills the wrapping dump window, consumer stalls.
        cpu_write(1, 8'hFE, 8'h11);
        cpu_write(1, 8'hFF, 8'h22);
        cpu_write(1, 8'h00, 8'h33);
        cpu_write(1, 8'h01, 8'h44);
        cpu_stop_now(1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            check("t5_addr", 1, obs[1].mem_addr, ea[n]);
            check("t5_data", 1, obs[1].out_data, ed[n]);
            stim[1].out_ready = rpat[i];
            tick();
            if (rpat[i]) n++;
        end
        stim[1].out_ready = 1'b0;
        check("t5_done", 1, obs[1].done, 1'b1);
        check("t5_run_cycles", 1, obs[1].run_cycles, 16'd4);
        check("t5_timeout", 1, obs[1].timeout, 1'b0);

        // 6: 256-byte load (load_len=0) with a stray start mid-load.
        do_start(1, 8'd0);
        wbase = wcnt[1];
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                stim[1].start    = 1'b1;
                stim[1].load_len = 8'd3;
            end
            if (i == 255) check("t6_still_loading", 1, obs[1].in_ready, 1'b1);
            feed(1, 8'h01);
            stim[1].start = 1'b0;
        end
        check("t6_writes", 1, wcnt[1] - wbase, 256);
        check("t6_mem0", 1, env_mem[1][0], 8'h01);
        check("t6_mem128", 1, env_mem[1][128], 8'h01);
        check("t6_mem255", 1, env_mem[1][255], 8'h01);
        check("t6_checksum", 1, obs[1].checksum, 8'h00);
        check("t6_run", 1, obs[1].cpu_rst, 1'b0);
        cpu_stop_now(1);
        stim[1].out_ready = 1'b1;
        wait_for(1, W_DONE);
        stim[1].out_ready = 1'b0;

        // Reset in the middle of RUN.
        do_start(0, 8'd1);
        feed(0, 8'h5A);
        check("rs_running", 0, obs[0].cpu_rst, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rs_cpu_rst", 0, obs[0].cpu_rst, 1'b1);
        check("rs_busy", 0, obs[0].busy, 1'b0);
        check("rs_run_cycles", 0, obs[0].run_cycles, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("rs_idle_cpu_rst", 0, obs[0].cpu_rst, 1'b1);
        check("rs_idle_done", 1, obs[1].done, 1'b0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
